// File: rtl/floo_id_order_tracker.sv
// Per-ID ordering tracker: admits a request only if it cannot be reordered
// against earlier outstanding requests of the same ID, and optionally merges
// the final responses of a multicast request into one forwarded response.
module floo_id_order_tracker #(
   parameter int unsigned IdWidth       = 4,
   parameter int unsigned MaxTxnsPerId  = 8,
   parameter int unsigned NumDest       = 4,
   parameter bit          MergeMcastRsp = 1'b1,
   localparam int unsigned CntW         = $clog2(MaxTxnsPerId + 1),
   localparam int unsigned DestW        = (NumDest > 1) ? $clog2(NumDest) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   // upstream request
   input  logic               ax_valid_i,
   output logic               ax_ready_o,
   input  logic [IdWidth-1:0] ax_id_i,
   input  logic               ax_mcast_i,
   input  logic [DestW-1:0]   ax_dest_i,
   input  logic [NumDest-1:0] ax_mask_i,
   // downstream request handshake
   output logic               ax_valid_o,
   input  logic               ax_ready_i,
   // incoming response
   input  logic               rsp_valid_i,
   output logic               rsp_ready_o,
   input  logic [IdWidth-1:0] rsp_id_i,
   input  logic               rsp_last_i,
   // outgoing response handshake
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   // status
   output logic               busy_o,
   output logic               err_o
);

   localparam int unsigned NumIds = 2 ** IdWidth;
   localparam logic [CntW-1:0] CntOne = 1;

   logic [CntW-1:0]    cnt_q   [NumIds];
   logic [CntW-1:0]    cnt_d   [NumIds];
   logic [DestW-1:0]   dest_q  [NumIds];
   logic [DestW-1:0]   dest_d  [NumIds];
   logic [NumDest-1:0] mask_q  [NumIds];
   logic [NumDest-1:0] mask_d  [NumIds];
   logic               mcast_q [NumIds];
   logic               mcast_d [NumIds];
   logic [CntW-1:0]    mrg_q   [NumIds];
   logic [CntW-1:0]    mrg_d   [NumIds];
   logic               err_q;

   logic        allow;
   logic        push;
   logic        pop;
   logic        absorb;
   logic        err_set;
   logic        rsp_live;
   logic        rsp_hs;
   int unsigned n_exp;

   // Admission check against the entry addressed by the incoming request.
   always_comb begin
      logic [CntW-1:0] a_cnt;
      logic            compat;
      a_cnt  = cnt_q[ax_id_i];
      compat = (a_cnt == '0) ||
               (!ax_mcast_i && !mcast_q[ax_id_i] && (ax_dest_i == dest_q[ax_id_i])) ||
               (ax_mcast_i && mcast_q[ax_id_i] && (ax_mask_i == mask_q[ax_id_i]));
      allow  = compat && (32'(a_cnt) < MaxTxnsPerId);
      // Only one merged multicast may be in flight per ID.
      if (MergeMcastRsp && ax_mcast_i && (a_cnt != '0)) allow = 1'b0;
      ax_valid_o = ax_valid_i && allow;
      ax_ready_o = allow && ax_ready_i;
      push       = ax_valid_i && allow && ax_ready_i;
   end

   // Response routing: absorb all but the last final beat of a merged multicast.
   always_comb begin
      logic merge;
      rsp_live = cnt_q[rsp_id_i] != '0;
      merge    = MergeMcastRsp && rsp_last_i && mcast_q[rsp_id_i] && rsp_live;
      n_exp    = 0;
      for (int i = 0; i < int'(NumDest); i++) n_exp += 32'(mask_q[rsp_id_i][i]);
      // An empty mask still expects exactly one response.
      if (n_exp == 0) n_exp = 1;
      absorb      = merge && (32'(mrg_q[rsp_id_i]) < (n_exp - 1));
      rsp_valid_o = rsp_valid_i && !absorb;
      rsp_ready_o = absorb ? 1'b1 : rsp_ready_i;
      rsp_hs      = rsp_valid_i && rsp_ready_i && !absorb;
      pop         = rsp_hs && rsp_last_i && rsp_live;
      err_set     = rsp_hs && rsp_last_i && !rsp_live;
   end

   // Entry next-state; push and pop on the same ID cancel in the counter.
   always_comb begin
      cnt_d   = cnt_q;
      dest_d  = dest_q;
      mask_d  = mask_q;
      mcast_d = mcast_q;
      mrg_d   = mrg_q;
      if (push) begin
         cnt_d[ax_id_i]   = cnt_d[ax_id_i] + CntOne;
         dest_d[ax_id_i]  = ax_dest_i;
         mask_d[ax_id_i]  = ax_mask_i;
         mcast_d[ax_id_i] = ax_mcast_i;
      end
      if (pop) begin
         cnt_d[rsp_id_i] = cnt_d[rsp_id_i] - CntOne;
         mrg_d[rsp_id_i] = '0;
      end
      if (absorb && rsp_valid_i) mrg_d[rsp_id_i] = mrg_q[rsp_id_i] + CntOne;
   end

   // Busy whenever any ID has outstanding transactions.
   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < int'(NumIds); i++) busy_o |= (cnt_q[i] != '0);
   end

   assign err_o = err_q;

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '{default: '0};
         dest_q  <= '{default: '0};
         mask_q  <= '{default: '0};
         mcast_q <= '{default: 1'b0};
         mrg_q   <= '{default: '0};
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         dest_q  <= dest_d;
         mask_q  <= mask_d;
         mcast_q <= mcast_d;
         mrg_q   <= mrg_d;
         err_q   <= err_q | err_set;
      end
   end

endmodule

// File: tb/tb_floo_id_order_tracker.sv
// Bench for floo_id_order_tracker: a table of per-cycle input vectors with
// expected outputs, routed through a scoreboard queue and compared mid-cycle.
module tb_floo_id_order_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic       ax_valid_i, ax_ready_o, ax_mcast_i, ax_valid_o, ax_ready_i;
   logic [3:0] ax_id_i, ax_mask_i, rsp_id_i;
   logic [1:0] ax_dest_i;
   logic       rsp_valid_i, rsp_ready_o, rsp_last_i, rsp_valid_o, rsp_ready_i;
   logic       busy_o, err_o;

   floo_id_order_tracker #(
      .IdWidth      (4),
      .MaxTxnsPerId (8),
      .NumDest      (4),
      .MergeMcastRsp(1'b1)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .ax_valid_i (ax_valid_i),
      .ax_ready_o (ax_ready_o),
      .ax_id_i    (ax_id_i),
      .ax_mcast_i (ax_mcast_i),
      .ax_dest_i  (ax_dest_i),
      .ax_mask_i  (ax_mask_i),
      .ax_valid_o (ax_valid_o),
      .ax_ready_i (ax_ready_i),
      .rsp_valid_i(rsp_valid_i),
      .rsp_ready_o(rsp_ready_o),
      .rsp_id_i   (rsp_id_i),
      .rsp_last_i (rsp_last_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i),
      .busy_o     (busy_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   // Expected bits: [5]ax_valid_o [4]ax_ready_o [3]rsp_valid_o [2]rsp_ready_o [1]busy [0]err
   typedef struct {
      logic       rst;
      logic       av;
      logic [3:0] aid;
      logic       amc;
      logic [1:0] adst;
      logic [3:0] amask;
      logic       ardy;
      logic       rv;
      logic [3:0] rid;
      logic       rlast;
      logic       rrdy;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic add(input logic r, input logic av, input int aid, input logic amc,
                      input int adst, input int amask, input logic ardy, input logic rv,
                      input int rid, input logic rlast, input logic rrdy, input logic [5:0] e);
      vec_t v;
      v.rst = r; v.av = av; v.aid = 4'(aid); v.amc = amc; v.adst = 2'(adst);
      v.amask = 4'(amask); v.ardy = ardy; v.rv = rv; v.rid = 4'(rid);
      v.rlast = rlast; v.rrdy = rrdy; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic add_ax(input int aid, input logic amc, input int adst, input int amask,
                         input logic [5:0] e);
      add(0, 1, aid, amc, adst, amask, 1, 0, 0, 0, 1, e);
   endtask

   task automatic add_rsp(input int rid, input logic rlast, input logic rrdy,
                          input logic [5:0] e);
      add(0, 0, 0, 0, 0, 0, 0, 1, rid, rlast, rrdy, e);
   endtask

   task automatic add_both(input int aid, input int adst, input int rid, input logic [5:0] e);
      add(0, 1, aid, 0, adst, 0, 1, 1, rid, 1, 1, e);
   endtask

   task automatic add_idle(input logic r, input logic [5:0] e);
      add(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, e);
   endtask

   task automatic check(input int idx, input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL vec %0d %s: got %b expected %b", idx, name, act, req);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; ax_valid_i = v.av; ax_id_i = v.aid; ax_mcast_i = v.amc;
      ax_dest_i = v.adst; ax_mask_i = v.amask; ax_ready_i = v.ardy;
      rsp_valid_i = v.rv; rsp_id_i = v.rid; rsp_last_i = v.rlast; rsp_ready_i = v.rrdy;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t idle0, e;
      // Reset state
      add_idle(0, 6'b000100);
      // ID 3 locked to dest 1 until its three responses drain
      add_ax(3, 0, 1, 0, 6'b110100);
      add_ax(3, 0, 1, 0, 6'b110110);
      add_ax(3, 0, 1, 0, 6'b110110);
      add_ax(3, 0, 2, 0, 6'b000110);
      for (int i = 0; i < 3; i++) add_both(3, 2, 3, 6'b001110);
      add_ax(3, 0, 2, 0, 6'b110100);
      add_rsp(3, 0, 0, 6'b001010);      // non-last beat passes ready through
      add_rsp(3, 1, 1, 6'b001110);
      // Fill ID 0 to the limit
      add_ax(0, 0, 0, 0, 6'b110100);
      for (int i = 0; i < 7; i++) add_ax(0, 0, 0, 0, 6'b110110);
      add_ax(0, 0, 0, 0, 6'b000110);
      add_both(0, 0, 0, 6'b001110);     // same-cycle pop does not re-enable
      add_ax(0, 0, 0, 0, 6'b110110);
      for (int i = 0; i < 8; i++) add_rsp(0, 1, 1, 6'b001110);
      // Multicast mask 1011: two final beats absorbed, third forwarded
      add_ax(5, 1, 0, 4'b1011, 6'b110100);
      add_ax(5, 1, 0, 4'b1011, 6'b000110);
      add_rsp(5, 1, 1, 6'b000110);
      add_rsp(5, 1, 0, 6'b000110);      // absorbed beats are accepted regardless
      add_rsp(5, 1, 0, 6'b001010);
      add_rsp(5, 1, 1, 6'b001110);
      // Empty multicast mask expects a single response
      add_ax(6, 1, 0, 0, 6'b110100);
      add_rsp(6, 1, 1, 6'b001110);
      add_idle(0, 6'b000100);
      // Same-cycle push and pop on ID 2 with cnt 2
      add_ax(2, 0, 1, 0, 6'b110100);
      add_ax(2, 0, 1, 0, 6'b110110);
      add_both(2, 1, 2, 6'b111110);
      add_idle(0, 6'b000110);
      add_rsp(2, 1, 1, 6'b001110);
      add_rsp(2, 1, 1, 6'b001110);
      add_idle(0, 6'b000100);
      // Orphan final response raises a sticky error
      add_rsp(7, 1, 1, 6'b001100);
      add_idle(0, 6'b000101);
      add_idle(0, 6'b000101);
      add_idle(1, 6'b000101);
      add_idle(0, 6'b000100);
      // Reset with IDs 1 and 4 outstanding
      add_ax(1, 0, 0, 0, 6'b110100);
      add_ax(4, 0, 3, 0, 6'b110110);
      add_idle(1, 6'b000110);
      add_ax(1, 0, 2, 0, 6'b110100);
      add_rsp(4, 1, 1, 6'b001110);
      add_idle(0, 6'b000111);

      idle0 = vecs[0];
      idle0.rst = 1'b1;
      drive(idle0);
      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #1;
         drive(vecs[i]);
         sb.push_back(vecs[i]);
         @(negedge clk);
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL vec %0d scoreboard: got empty queue expected entry", i);
         end else begin
            e = sb.pop_front();
            check(i, "ax_valid_o",  ax_valid_o,  e.exp[5]);
            check(i, "ax_ready_o",  ax_ready_o,  e.exp[4]);
            check(i, "rsp_valid_o", rsp_valid_o, e.exp[3]);
            check(i, "rsp_ready_o", rsp_ready_o, e.exp[2]);
            check(i, "busy_o",      busy_o,      e.exp[1]);
            check(i, "err_o",       err_o,       e.exp[0]);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
